acc_bank: RTL and testbench

ACC_BANK -- requirements
Module: acc_bank

---
 rtl/acc_bank.sv | 152 +++++++++++++++
 tb/tb_acc_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_bank.sv
// Accumulator bank between a MAC array and the post-processing unit: stores
// partial-sum rows during accumulation, feeds them back, then drains them out.
module acc_bank #(
    parameter int LANES = 16,
    parameter int ACC_W = 24,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(DEPTH)-1:0]     rows_m1,
    input  logic                         wr_valid,
    input  logic [LANES*ACC_W-1:0]       wr_data,
    input  logic                         tile_end,
    output logic [LANES*ACC_W-1:0]       to_mac,
    output logic                         wrap,
    output logic                         ppu_valid,
    input  logic                         ppu_ready,
    output logic [LANES*ACC_W-1:0]       ppu_data,
    output logic                         ppu_last,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = LANES * ACC_W;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] ptr_r;
    logic [AW-1:0] lim_r;
    logic [DW-1:0] entry_r [DEPTH];
    logic          wrap_r;
    logic          done_r;

    logic start_acc_s;
    logic wr_acc_s;
    logic tile_acc_s;
    logic hs_s;
    logic last_hs_s;
    logic at_lim_s;

    assign at_lim_s    = (ptr_r == lim_r);
    assign start_acc_s = (state_r == ST_IDLE)  && start;
    assign wr_acc_s    = (state_r == ST_ACCUM) && wr_valid;
    assign tile_acc_s  = (state_r == ST_ACCUM) && tile_end;
    assign hs_s        = (state_r == ST_DRAIN) && ppu_ready;
    assign last_hs_s   = hs_s && at_lim_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_ACCUM;
                else       state_nxt_s = ST_IDLE;
            end
            ST_ACCUM: begin
                if (tile_end) state_nxt_s = ST_DRAIN;
                else          state_nxt_s = ST_ACCUM;
            end
            ST_DRAIN: begin
                if (ppu_ready && at_lim_s) state_nxt_s = ST_IDLE;
                else                       state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pointer, row limit and single-cycle pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r  <= '0;
            lim_r  <= '0;
            wrap_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            wrap_r <= wr_acc_s && at_lim_s;
            done_r <= last_hs_s;
            // tile_end wins over a same-cycle write; the write itself still lands at the old ptr
            if (start_acc_s) begin
                lim_r <= rows_m1;
                ptr_r <= '0;
            end else if (tile_acc_s) begin
                ptr_r <= '0;
            end else if (wr_acc_s) begin
                ptr_r <= at_lim_s ? '0 : ptr_r + PTR_ONE;
            end else if (last_hs_s) begin
                ptr_r <= '0;
            end else if (hs_s) begin
                ptr_r <= ptr_r + PTR_ONE;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Entry storage: cleared on reset and on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entry_r[i] <= '0;
        end else if (start_acc_s) begin
            for (int i = 0; i < DEPTH; i++) entry_r[i] <= '0;
        end else if (wr_acc_s) begin
            entry_r[ptr_r] <= wr_data;
        end else begin
            entry_r[ptr_r] <= entry_r[ptr_r];
        end
    end

    // Output views of the entry at the pointer, gated by state
    always_comb begin
        to_mac    = '0;
        ppu_data  = '0;
        ppu_valid = 1'b0;
        ppu_last  = 1'b0;
        case (state_r)
            ST_ACCUM: begin
                to_mac = entry_r[ptr_r];
            end
            ST_DRAIN: begin
                ppu_valid = 1'b1;
                ppu_data  = entry_r[ptr_r];
                ppu_last  = at_lim_s;
            end
            default: begin
                to_mac = '0;
            end
        endcase
    end

    assign busy = (state_r != ST_IDLE);
    assign wrap = wrap_r;
    assign done = done_r;

endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench for acc_bank: a transaction-level model predicts stored rows
// and the drained beat sequence; a monitor checks every presented beat.
module tb_acc_bank;
    localparam int LANES = 16;
    localparam int ACC_W = 24;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = LANES * ACC_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rows_m1;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          tile_end;
    logic [DW-1:0] to_mac;
    logic          wrap;
    logic          ppu_valid;
    logic          ppu_ready;
    logic [DW-1:0] ppu_data;
    logic          ppu_last;
    logic          busy;
    logic          done;

    acc_bank #(.LANES(LANES), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rows_m1(rows_m1),
        .wr_valid(wr_valid), .wr_data(wr_data), .tile_end(tile_end),
        .to_mac(to_mac), .wrap(wrap), .ppu_valid(ppu_valid), .ppu_ready(ppu_ready),
        .ppu_data(ppu_data), .ppu_last(ppu_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } beat_t;

    beat_t         sb_q[$];
    logic [DW-1:0] mem [DEPTH];
    int            m_ptr;
    int            m_lim;
    int            m_mode;   // 0 idle, 1 accumulating, 2 draining
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = ACC_W'($urandom);
        return r;
    endfunction

    function automatic logic [DW-1:0] splat(input int v);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = ACC_W'(v);
        return r;
    endfunction

    // Monitor: every presented beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && ppu_valid) begin
            if (sb_q.size() == 0) begin
                chk1("unexpected_beat", ppu_valid, 1'b0);
            end else begin
                chkd("ppu_data", ppu_data, sb_q[0].d);
                chk1("ppu_last", ppu_last, sb_q[0].last);
                if (ppu_ready) void'(sb_q.pop_front());
            end
        end
    end

    // One non-drain cycle: drive inputs, advance the model, check the result
    task automatic cycle(input bit st, input int rows, input bit wv,
                         input logic [DW-1:0] wd, input bit te);
        bit exp_wrap = 1'b0;
        start = st; rows_m1 = AW'(rows); wr_valid = wv; wr_data = wd; tile_end = te;
        if (m_mode == 0 && st) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
            m_lim = rows; m_ptr = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            if (wv) begin
                mem[m_ptr] = wd;
                if (m_ptr == m_lim) begin exp_wrap = 1'b1; m_ptr = 0; end
                else m_ptr = m_ptr + 1;
            end
            if (te) begin
                m_ptr = 0; m_mode = 2;
                for (int i = 0; i <= m_lim; i++) sb_q.push_back('{mem[i], i == m_lim});
            end
        end
        @(posedge clk); #1;
        start = 1'b0; wr_valid = 1'b0; tile_end = 1'b0;
        chk1("wrap", wrap, exp_wrap);
        chk1("busy", busy, m_mode != 0);
        chk1("done_quiet", done, 1'b0);
        chkd("to_mac", to_mac, (m_mode == 1) ? mem[m_ptr] : '0);
        if (m_mode != 2) begin
            chk1("ppu_valid_off", ppu_valid, 1'b0);
            chkd("ppu_data_off", ppu_data, '0);
        end
    endtask

    // Drain all beats; sel 0 = always ready, 1 = 0,0,1,0,1 pattern, else random
    task automatic drain(input int sel, input bit noise);
        int hs = 0;
        int cyc = 0;
        bit r;
        while (hs < m_lim + 1 && cyc < 2000) begin
            case (sel)
                0:       r = 1'b1;
                1:       r = (cyc % 5 == 2) || (cyc % 5 == 4);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ppu_ready = r;
            if (noise) begin
                start = 1'($urandom_range(0, 1)); rows_m1 = AW'($urandom_range(0, DEPTH - 1));
                wr_valid = 1'($urandom_range(0, 1)); wr_data = rand_row();
                tile_end = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            start = 1'b0; wr_valid = 1'b0; tile_end = 1'b0;
            if (r) hs++;
            cyc++;
            chk1("done", done, hs == m_lim + 1);
            chk1("busy_drain", busy, hs != m_lim + 1);
            chkd("to_mac_drain", to_mac, '0);
        end
        chk1("drain_bound", hs == m_lim + 1, 1'b1);
        ppu_ready = 1'b0;
        m_mode = 0; m_ptr = 0;
        @(posedge clk); #1;
        chk1("sb_empty", sb_q.size() == 0, 1'b1);
        chk1("done_one_cycle", done, 1'b0);
        chk1("ppu_valid_idle", ppu_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rows_m1 = '0; wr_valid = 1'b0; wr_data = '0;
        tile_end = 1'b0; ppu_ready = 1'b0;
        m_ptr = 0; m_lim = 0; m_mode = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_wrap", wrap, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ppu_valid", ppu_valid, 1'b0);
        chk1("rst_ppu_last", ppu_last, 1'b0);
        chkd("rst_to_mac", to_mac, '0);
        chkd("rst_ppu_data", ppu_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic tile: rows 1..4, wrap after 4th write, entry 0 back on to_mac
        cycle(1, 3, 0, '0, 0);
        for (int k = 1; k <= 4; k++) cycle(0, 0, 1, splat(k), 0);
        chkd("to_mac_entry0", to_mac, splat(1));
        cycle(0, 0, 0, '0, 0);
        // start while accumulating is ignored
        cycle(1, 9, 0, '0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, rand_row(), 0);
        cycle(0, 0, 0, '0, 1);
        drain(0, 0);

        // Idle: writes and tile_end ignored, entries persist until start
        cycle(0, 0, 1, rand_row(), 1);
        cycle(0, 0, 0, '0, 0);

        // Start clears the old rows; stalled drain with noise on other inputs
        cycle(1, 7, 0, '0, 0);
        cycle(0, 0, 1, rand_row(), 0);
        cycle(0, 0, 1, rand_row(), 0);
        cycle(0, 0, 0, '0, 1);
        drain(1, 1);

        // Write and tile_end together at ptr 2
        cycle(1, 5, 0, '0, 0);
        cycle(0, 0, 1, rand_row(), 0);
        cycle(0, 0, 1, rand_row(), 0);
        cycle(0, 0, 1, rand_row(), 1);
        drain(2, 0);

        // Random tiles
        for (int t = 0; t < 6; t++) begin
            int rows = $urandom_range(0, DEPTH - 1);
            int nw = $urandom_range(0, 2 * (rows + 1));
            cycle(1, rows, 0, '0, 0);
            for (int k = 0; k < nw; k++) begin
                bit wv = 1'($urandom_range(0, 3) != 0);
                cycle(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), wv, rand_row(), 0);
            end
            cycle(0, 0, 1'($urandom_range(0, 1)), rand_row(), 1);
            drain(2, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a drain at ptr 5
        cycle(1, 15, 0, '0, 0);
        for (int k = 0; k < 16; k++) cycle(0, 0, 1, rand_row(), 0);
        cycle(0, 0, 0, '0, 1);
        ppu_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", ppu_valid, 1'b0);
        chk1("mid_rst_last", ppu_last, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk1("mid_rst_wrap", wrap, 1'b0);
        chkd("mid_rst_ppu_data", ppu_data, '0);
        chkd("mid_rst_to_mac", to_mac, '0);
        chk1("mid_rst_beats_left", sb_q.size() == 11, 1'b1);
        sb_q.delete();
        ppu_ready = 1'b0;
        m_mode = 0; m_ptr = 0; m_lim = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        @(posedge clk); #1;
        chk1("post_rst_idle", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1, 15, 0, '0, 0);
        chkd("post_rst_to_mac", to_mac, '0);
        cycle(0, 0, 0, '0, 1);
        drain(2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
